// File: rtl/survivor_traceback.sv
// Survivor-memory traceback for a 4-state rate-1/2 Viterbi decoder.
// It buffers DEPTH decision vectors, traces back from start_state, then emits the decoded bits oldest first.
module survivor_traceback #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic [3:0] dec,
  input  logic [1:0] start_state,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_bit,
  input  logic       out_ready,
  output logic [1:0] fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid/ready are sampled there, and data must be stable while valid is high and ready is low.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wptr, rptr, idx;
  logic [1:0]      cur_state;
  logic [3:0]      mem [DEPTH];
  logic [DEPTH-1:0] outbuf;
  logic [3:0]      rd_vec;
  logic            accept, handshake;

  assign accept    = dec_valid && (state == FILL);
  assign handshake = out_ready && (state == EMIT);
  assign rd_vec    = mem[rptr];
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && wptr == LAST) state_nxt = TRACE;
      TRACE:   if (rptr == '0) state_nxt = EMIT;
      EMIT:    if (handshake && idx == LAST) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL);
    out_valid = (state == EMIT);
    out_bit   = (state == EMIT) ? outbuf[idx] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      idx       <= '0;
      cur_state <= 2'd0;
    end else begin
      case (state)
        FILL: begin
          idx <= '0;
          if (accept) begin
            if (wptr == LAST) begin
              wptr      <= '0;
              rptr      <= LAST;
              cur_state <= start_state;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        TRACE: begin
          // Step back to the predecessor selected by this state's decision bit.
          cur_state <= {cur_state[0], rd_vec[cur_state]};
          if (rptr != '0) rptr <= rptr - 1'b1;
          idx <= '0;
        end
        EMIT: begin
          if (handshake) idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        default: begin
          wptr <= '0;
          rptr <= '0;
          idx  <= '0;
        end
      endcase
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (accept)          mem[wptr]    <= dec;
    if (state == TRACE)  outbuf[rptr] <= cur_state[1];
  end

endmodule
